// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART types and helpers: receiver state encoding, rounded
//            baud divisor and 2-of-3 majority vote.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Clock cycles per oversample tick, rounded to nearest and never below one.
  function automatic int calc_div(input int clk_freq, input int baud_rate,
                                  input int oversample);
    int den;
    int div;
    den = baud_rate * oversample;
    div = (clk_freq + den / 2) / den;
    return (div < 1) ? 1 : div;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_tick
// Brief    : Free-running oversample tick generator, one-cycle pulse every
//            round(CLK_FREQ/(BAUD_RATE*OVERSAMPLE)) clocks.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9_600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk_fpga,
  input  logic reset,
  output logic tick
);

  localparam int c_div = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int c_cw  = (c_div > 1) ? $clog2(c_div) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(c_div - 1);

  logic [c_cw-1:0] r_cnt;

  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_cnt == c_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param
// Brief    : Parametrised oversampling UART receiver with majority voting,
//            false-start rejection, framing/overrun detection and valid/ready
//            output. Optional parity checking enabled by UART_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9_600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk_fpga,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int c_sw = $clog2(OVERSAMPLE);
  localparam logic [c_sw-1:0] c_samp_a    = c_sw'(OVERSAMPLE / 2 - 1);
  localparam logic [c_sw-1:0] c_samp_b    = c_sw'(OVERSAMPLE / 2);
  localparam logic [c_sw-1:0] c_samp_c    = c_sw'(OVERSAMPLE / 2 + 1);
  localparam logic [c_sw-1:0] c_samp_last = c_sw'(OVERSAMPLE - 1);
  localparam logic [3:0]      c_data_last = 4'(DATA_BITS - 1);
  localparam logic [3:0]      c_stop_last = 4'(STOP_BITS - 1);

  logic                 r_rxd_meta;
  logic                 r_rxd_sync;
  logic                 w_tick;
  uart_state_t          r_state;
  logic [c_sw-1:0]      r_sample_cnt;
  logic [3:0]           r_bit_cnt;
  logic [1:0]           r_vote;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_ferr_acc;
  logic                 r_armed;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  logic w_maj;
  logic w_decide;
  logic w_bit_end;
  logic w_accept;
  logic w_frame_err_final;

  uart_baud_tick #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud_tick (
    .clk_fpga (clk_fpga),
    .reset    (reset),
    .tick     (w_tick)
  );

  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
    end else begin
      r_rxd_meta <= rxd;
      r_rxd_sync <= r_rxd_meta;
    end
  end

  // Third vote is the live sample, so the decision lands on tick M+1.
  assign w_maj             = majority3(r_vote[0], r_vote[1], r_rxd_sync);
  assign w_decide          = w_tick && (r_sample_cnt == c_samp_c);
  assign w_bit_end         = w_tick && (r_sample_cnt == c_samp_last);
  assign w_accept          = r_rx_valid && rx_ready;
  assign w_frame_err_final = r_ferr_acc | ~w_maj;

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_err;
  logic w_parity_err_final;
  assign w_parity_err_final = ((^r_shift) ^ r_par_bit) != (PARITY_ODD != 0);
  assign parity_err         = r_parity_err;
`else
  logic w_unused_parity_odd;
  assign w_unused_parity_odd = (PARITY_ODD != 0);
  assign parity_err          = 1'b0;
`endif

  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      r_state      <= IDLE;
      r_sample_cnt <= '0;
      r_bit_cnt    <= '0;
      r_vote       <= 2'b11;
      r_shift      <= '0;
      r_ferr_acc   <= 1'b0;
      r_armed      <= 1'b1;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_overrun <= 1'b0;
      if (w_accept) begin
        r_rx_valid <= 1'b0;
      end

      if (w_tick && (r_state != IDLE)) begin
        if (r_sample_cnt == c_samp_a) r_vote[0] <= r_rxd_sync;
        if (r_sample_cnt == c_samp_b) r_vote[1] <= r_rxd_sync;
        r_sample_cnt <= (r_sample_cnt == c_samp_last) ? '0 : r_sample_cnt + 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_tick) begin
            if (r_rxd_sync) begin
              r_armed <= 1'b1;
            end else if (r_armed) begin
              r_state      <= START;
              r_sample_cnt <= '0;
              r_bit_cnt    <= '0;
              r_ferr_acc   <= 1'b0;
            end
          end
        end

        START: begin
          if (w_decide && w_maj) begin
            r_state <= IDLE;
          end else if (w_bit_end) begin
            r_state <= DATA;
          end
        end

        DATA: begin
          if (w_decide) begin
            r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
          end
          if (w_bit_end) begin
            if (r_bit_cnt == c_data_last) begin
              r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              r_state   <= PARITY;
`else
              r_state   <= STOP;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end

        PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (w_decide) begin
            r_par_bit <= w_maj;
          end
          if (w_bit_end) begin
            r_state <= STOP;
          end
`else
          r_state <= IDLE;
`endif
        end

        STOP: begin
          if (w_decide && !w_maj) begin
            r_ferr_acc <= 1'b1;
          end
          // Completing mid-bit leaves time to catch a back-to-back start edge.
          if (w_decide && (r_bit_cnt == c_stop_last)) begin
            r_state <= IDLE;
            if (!r_rx_valid || w_accept) begin
              r_rx_data    <= r_shift;
              r_frame_err  <= w_frame_err_final;
              r_rx_valid   <= 1'b1;
`ifdef UART_RX_PARITY_EN
              r_parity_err <= w_parity_err_final;
`endif
            end else begin
              r_overrun <= 1'b1;
            end
            // A break reports once, then waits for the line to go high again.
            if (w_frame_err_final && (r_shift == '0)) begin
              r_armed <= 1'b0;
            end
          end else if (w_bit_end) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun;
  assign busy        = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_param
// Brief    : Self-checking bench for uart_rx_param: two configurations (8N1 x16
//            and 7-bit/2-stop x8), frames compared against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

  localparam int CLK_FREQ = 1_000_000;
  localparam int A_BAUD   = 31_250;
  localparam int A_OS     = 16;
  localparam int B_BAUD   = 62_500;
  localparam int B_OS     = 8;
  localparam int PAR_ODD  = 0;
  localparam int DIV_A    = (CLK_FREQ + A_BAUD * A_OS / 2) / (A_BAUD * A_OS);
  localparam int DIV_B    = (CLK_FREQ + B_BAUD * B_OS / 2) / (B_BAUD * B_OS);
  localparam int BIT_A    = DIV_A * A_OS;
  localparam int BIT_B    = DIV_B * B_OS;

  typedef struct {
    logic [8:0] data;
    logic       ferr;
    logic       perr;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a = 1'b1, reset_b = 1'b1;
  logic       rxd_a = 1'b1, rxd_b = 1'b1;
  logic       ready_a = 1'b1, ready_b = 1'b1;
  logic [7:0] rx_data_a;
  logic [6:0] rx_data_b;
  logic       rx_valid_a, frame_err_a, parity_err_a, overrun_err_a, busy_a;
  logic       rx_valid_b, frame_err_b, parity_err_b, overrun_err_b, busy_b;

  uart_rx_param #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(A_BAUD), .OVERSAMPLE(A_OS),
    .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(PAR_ODD)
  ) dut_a (
    .clk_fpga(clk), .reset(reset_a), .rxd(rxd_a), .rx_data(rx_data_a),
    .rx_valid(rx_valid_a), .rx_ready(ready_a), .frame_err(frame_err_a),
    .parity_err(parity_err_a), .overrun_err(overrun_err_a), .busy(busy_a)
  );

  uart_rx_param #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(B_BAUD), .OVERSAMPLE(B_OS),
    .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(PAR_ODD)
  ) dut_b (
    .clk_fpga(clk), .reset(reset_b), .rxd(rxd_b), .rx_data(rx_data_b),
    .rx_valid(rx_valid_b), .rx_ready(ready_b), .frame_err(frame_err_b),
    .parity_err(parity_err_b), .overrun_err(overrun_err_b), .busy(busy_b)
  );

  rec_t q_a[$];
  rec_t q_b[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   valid_a_cyc = 0;
  int   busy_a_cyc = 0;
  int   ovr_a = 0;
  int   ovr_b = 0;

  // Accepted words are recorded mid-cycle, where valid/ready are stable.
  always @(negedge clk) begin
    if (rx_valid_a && ready_a) q_a.push_back('{9'(rx_data_a), frame_err_a, parity_err_a});
    if (rx_valid_b && ready_b) q_b.push_back('{9'(rx_data_b), frame_err_b, parity_err_b});
    if (overrun_err_a) ovr_a++;
    if (overrun_err_b) ovr_b++;
    if (rx_valid_a) valid_a_cyc++;
    if (busy_a) busy_a_cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_line(input bit sel, input logic v, input int n);
    if (sel) rxd_b = v;
    else     rxd_a = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic good_par(input bit sel, input logic [8:0] d);
    logic p;
    p = (PAR_ODD != 0);
    for (int i = 0; i < (sel ? 7 : 8); i++) p ^= d[i];
    return p;
  endfunction

  // Frame-level reference: what the consumer must see for a frame sent on the line.
  function automatic rec_t model(input bit sel, input logic [8:0] d, input logic par,
                                 input logic [1:0] stops);
    rec_t r;
    r.data = sel ? {2'b00, d[6:0]} : {1'b0, d[7:0]};
    r.ferr = sel ? !(stops[0] && stops[1]) : !stops[0];
`ifdef UART_RX_PARITY_EN
    r.perr = ((^r.data) ^ par) != (PAR_ODD != 0);
`else
    r.perr = 1'b0;
`endif
    return r;
  endfunction

  task automatic send(input bit sel, input logic [8:0] d, input logic par,
                      input logic [1:0] stops);
    int bt;
    bt = sel ? BIT_B : BIT_A;
    drive_line(sel, 1'b0, bt);
    for (int i = 0; i < (sel ? 7 : 8); i++) drive_line(sel, d[i], bt);
`ifdef UART_RX_PARITY_EN
    drive_line(sel, par, bt);
`endif
    for (int i = 0; i < (sel ? 2 : 1); i++) drive_line(sel, stops[i], bt);
  endtask

  function automatic int qsize(input bit sel);
    return sel ? q_b.size() : q_a.size();
  endfunction

  task automatic expect_frame(input bit sel, input logic [8:0] d, input logic par,
                              input logic [1:0] stops, input string tag);
    rec_t e;
    rec_t o;
    int   waited;
    e = model(sel, d, par, stops);
    waited = 0;
    while (qsize(sel) == 0 && waited < 4 * (sel ? BIT_B : BIT_A)) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check({tag, "_present"}, 32'(qsize(sel) != 0), 1);
    if (qsize(sel) != 0) begin
      if (sel) o = q_b.pop_front();
      else     o = q_a.pop_front();
      check({tag, "_data"}, o.data, e.data);
      check({tag, "_ferr"}, o.ferr, e.ferr);
      check({tag, "_perr"}, o.perr, e.perr);
    end
  endtask

  initial begin
    logic [8:0] d;
    logic       p;
    logic [1:0] s;
    int         base;

    repeat (4) @(posedge clk);
    #1;
    check("a_reset_data", rx_data_a, 0);
    check("a_reset_flags", {rx_valid_a, frame_err_a, parity_err_a, overrun_err_a, busy_a}, 0);
    check("b_reset_data", rx_data_b, 0);
    check("b_reset_flags", {rx_valid_b, frame_err_b, parity_err_b, overrun_err_b, busy_b}, 0);
    reset_a = 1'b0;
    reset_b = 1'b0;
    drive_line(0, 1'b1, 2 * BIT_A);

    // Single clean frame with the consumer always ready.
    valid_a_cyc = 0;
    send(0, 9'h55, good_par(0, 9'h55), 2'b11);
    drive_line(0, 1'b1, BIT_A);
    expect_frame(0, 9'h55, good_par(0, 9'h55), 2'b11, "a_55");
    check("a_55_valid_cycles", valid_a_cyc, 1);
    check("a_55_overrun", ovr_a, 0);

    for (int k = 0; k < 5; k++) begin
      d = 9'($urandom_range(0, 255));
      p = good_par(0, d) ^ ($urandom_range(0, 3) == 0);
      s = {1'b1, ($urandom_range(0, 4) != 0)};
      send(0, d, p, s);
      drive_line(0, 1'b1, BIT_A);
      expect_frame(0, d, p, s, "a_rand");
    end

    // Short low glitch must be rejected as a false start.
    busy_a_cyc  = 0;
    valid_a_cyc = 0;
    drive_line(0, 1'b0, 3 * DIV_A);
    drive_line(0, 1'b1, BIT_A);
    check("a_glitch_seen", 32'(busy_a_cyc != 0), 1);
    check("a_glitch_busy", busy_a, 0);
    check("a_glitch_valid", valid_a_cyc, 0);
    check("a_glitch_queue", q_a.size(), 0);

    // Back-to-back frames with the consumer stalled.
    ready_a = 1'b0;
    base    = ovr_a;
    send(0, 9'h11, good_par(0, 9'h11), 2'b11);
    send(0, 9'h22, good_par(0, 9'h22), 2'b11);
    drive_line(0, 1'b1, BIT_A);
    check("a_ovr_queue", q_a.size(), 0);
    check("a_ovr_valid", rx_valid_a, 1);
    check("a_ovr_data", rx_data_a, 8'h11);
    check("a_ovr_pulses", ovr_a - base, 1);
    ready_a = 1'b1;
    @(posedge clk);
    #1;
    check("a_ovr_cleared", rx_valid_a, 0);
    expect_frame(0, 9'h11, good_par(0, 9'h11), 2'b11, "a_ovr_first");

    // Framing error followed by a long break: exactly two reports.
    send(0, 9'hA3, good_par(0, 9'hA3), 2'b00);
    drive_line(0, 1'b0, 30 * BIT_A);
    drive_line(0, 1'b1, 2 * BIT_A);
    check("a_break_count", q_a.size(), 2);
    expect_frame(0, 9'hA3, good_par(0, 9'hA3), 2'b00, "a_brk_a3");
    expect_frame(0, 9'h00, 1'b0, 2'b00, "a_brk_zero");
    d = 9'($urandom_range(1, 255));
    send(0, d, good_par(0, d), 2'b11);
    drive_line(0, 1'b1, BIT_A);
    expect_frame(0, d, good_par(0, d), 2'b11, "a_rearm");

`ifdef UART_RX_PARITY_EN
    send(0, 9'h07, 1'b0, 2'b11);
    drive_line(0, 1'b1, BIT_A);
    expect_frame(0, 9'h07, 1'b0, 2'b11, "a_par0");
    send(0, 9'h07, 1'b1, 2'b11);
    drive_line(0, 1'b1, BIT_A);
    expect_frame(0, 9'h07, 1'b1, 2'b11, "a_par1");
`endif

    // Reset in data bit 4 while a word is still pending.
    ready_a = 1'b0;
    d = 9'($urandom_range(1, 255));
    send(0, d, good_par(0, d), 2'b11);
    drive_line(0, 1'b1, BIT_A);
    check("a_pend_valid", rx_valid_a, 1);
    check("a_pend_data", rx_data_a, d[7:0]);
    drive_line(0, 1'b0, BIT_A);
    for (int i = 0; i < 4; i++) drive_line(0, logic'(8'hC3 >> i), BIT_A);
    drive_line(0, 1'b0, BIT_A / 2);
    reset_a = 1'b1;
    @(posedge clk);
    #1;
    reset_a = 1'b0;
    check("a_rst_data", rx_data_a, 0);
    check("a_rst_flags", {rx_valid_a, frame_err_a, parity_err_a, overrun_err_a, busy_a}, 0);
    drive_line(0, 1'b1, 2 * BIT_A);
    ready_a = 1'b1;
    send(0, 9'hC3, good_par(0, 9'hC3), 2'b11);
    drive_line(0, 1'b1, BIT_A);
    expect_frame(0, 9'hC3, good_par(0, 9'hC3), 2'b11, "a_c3");

    // Second configuration: 7 data bits, 2 stop bits, x8 oversampling.
    drive_line(1, 1'b1, 2 * BIT_B);
    for (int k = 0; k < 5; k++) begin
      d = 9'($urandom_range(0, 127));
      p = good_par(1, d) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'($urandom_range(1, 2));
      send(1, d, p, s);
      drive_line(1, 1'b1, BIT_B);
      expect_frame(1, d, p, s, "b_rand");
    end
    send(1, 9'h5A, good_par(1, 9'h5A), 2'b01);
    drive_line(1, 1'b1, BIT_B);
    expect_frame(1, 9'h5A, good_par(1, 9'h5A), 2'b01, "b_stop2_low");

    ready_b = 1'b0;
    send(1, 9'h2B, good_par(1, 9'h2B), 2'b11);
    drive_line(1, 1'b1, BIT_B);
    check("b_pend_valid", rx_valid_b, 1);
    drive_line(1, 1'b0, BIT_B);
    for (int i = 0; i < 4; i++) drive_line(1, logic'(8'h5A >> i), BIT_B);
    drive_line(1, 1'b1, BIT_B / 2);
    reset_b = 1'b1;
    @(posedge clk);
    #1;
    reset_b = 1'b0;
    check("b_rst_data", rx_data_b, 0);
    check("b_rst_flags", {rx_valid_b, frame_err_b, parity_err_b, overrun_err_b, busy_b}, 0);
    drive_line(1, 1'b1, 2 * BIT_B);
    ready_b = 1'b1;
    send(1, 9'h5A, good_par(1, 9'h5A), 2'b11);
    drive_line(1, 1'b1, BIT_B);
    expect_frame(1, 9'h5A, good_par(1, 9'h5A), 2'b11, "b_5a");
    check("b_overrun", ovr_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
